// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction-decode stage feeding a clocked-read register file.
//   Fetch side : if_valid/if_ready handshake, if_instr, if_pc, flush (redirect kill).
//   RF side    : rf_addra/rf_addrb (combinational), rf_dataa/rf_datab (one cycle later),
//                wb_enc/wb_addrc/wb_datac (write-back port, observed for bypass).
//   Execute    : ex_valid/ex_ready handshake plus registered ID/EX fields
//                (pc, rs/rt/dst, bypassed operands, immediate, aluop, control flags).
module decode_stage #(
  parameter int XLEN = 32,
  parameter int RA   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [RA-1:0]   rf_addra,
  output logic [RA-1:0]   rf_addrb,
  input  logic [XLEN-1:0] rf_dataa,
  input  logic [XLEN-1:0] rf_datab,
  input  logic            wb_enc,
  input  logic [RA-1:0]   wb_addrc,
  input  logic [XLEN-1:0] wb_datac,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA-1:0]   ex_rs,
  output logic [RA-1:0]   ex_rt,
  output logic [RA-1:0]   ex_dst,
  output logic [XLEN-1:0] ex_rsdata,
  output logic [XLEN-1:0] ex_rtdata,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_aluop,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic            ex_bne,
  output logic            ex_jump,
  output logic            ex_jr,
  output logic            ex_link,
  output logic            ex_illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_LUI = 4'd9, ALU_UNS = 4'd10;

  logic [5:0]    op, funct;
  logic [RA-1:0] i_rs, i_rt, i_rd;
  logic [15:0]   i_imm;

  assign op    = if_instr[31:26];
  assign i_rs  = if_instr[25:21];
  assign i_rt  = if_instr[20:16];
  assign i_rd  = if_instr[15:11];
  assign funct = if_instr[5:0];
  assign i_imm = if_instr[15:0];

  // decoded fields for the instruction at fetch
  logic [RA-1:0] d_dst;
  logic [3:0]    d_aluop;
  logic d_rw, d_mr, d_mw, d_br, d_bne, d_j, d_jr, d_link, d_ill, d_zext, d_rdrt;

  always_comb begin
    d_dst = '0; d_aluop = ALU_ADD;
    d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_br = 1'b0; d_bne = 1'b0;
    d_j = 1'b0; d_jr = 1'b0; d_link = 1'b0; d_ill = 1'b0; d_zext = 1'b0; d_rdrt = 1'b0;
    case (op)
      6'h00: begin
        d_rw = 1'b1; d_dst = i_rd; d_rdrt = 1'b1;
        case (funct)
          6'h20: d_aluop = ALU_ADD;
          6'h21: d_aluop = ALU_UNS;
          6'h22: d_aluop = ALU_SUB;
          6'h23: d_aluop = ALU_UNS;
          6'h24: d_aluop = ALU_AND;
          6'h25: d_aluop = ALU_OR;
          6'h26: d_aluop = ALU_XOR;
          6'h27: d_aluop = ALU_NOR;
          6'h2A: d_aluop = ALU_SLT;
          6'h00: d_aluop = ALU_SLL;
          6'h02: d_aluop = ALU_SRL;
          6'h08: begin d_jr = 1'b1; d_rw = 1'b0; d_dst = '0; d_rdrt = 1'b0; end
          default: begin d_ill = 1'b1; d_rw = 1'b0; d_dst = '0; d_rdrt = 1'b0; end
        endcase
      end
      6'h08: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_ADD; end
      6'h09: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_UNS; end
      6'h0A: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_SLT; end
      6'h0C: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_AND; d_zext = 1'b1; end
      6'h0D: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_OR;  d_zext = 1'b1; end
      6'h0E: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_XOR; d_zext = 1'b1; end
      6'h0F: begin d_rw = 1'b1; d_dst = i_rt; d_aluop = ALU_LUI; end
      6'h23: begin d_rw = 1'b1; d_dst = i_rt; d_mr = 1'b1; end
      6'h2B: begin d_mw = 1'b1; d_rdrt = 1'b1; end
      6'h04: begin d_br = 1'b1; d_aluop = ALU_SUB; d_rdrt = 1'b1; end
      6'h05: begin d_br = 1'b1; d_bne = 1'b1; d_aluop = ALU_SUB; d_rdrt = 1'b1; end
      6'h02: d_j = 1'b1;
      6'h03: begin d_j = 1'b1; d_link = 1'b1; d_rw = 1'b1; d_dst = 5'd31; end
      default: d_ill = 1'b1;
    endcase
  end

  logic upd, load_use;
  assign upd      = !ex_valid || ex_ready;
  assign load_use = ex_valid && ex_memread && (ex_dst != '0) &&
                    ((ex_dst == i_rs) || ((ex_dst == i_rt) && d_rdrt));
  assign if_ready = upd && !load_use && !flush;

  // A held instruction keeps re-reading its own sources so its operands track
  // any write-back that lands while execute is stalled.
  assign rf_addra = upd ? i_rs : ex_rs;
  assign rf_addrb = upd ? i_rt : ex_rt;

  // The file reads before it writes, so a same-cycle write-back is captured here.
  logic            flag_a, flag_b;
  logic [XLEN-1:0] data_a, data_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      flag_a <= 1'b0; flag_b <= 1'b0; data_a <= '0; data_b <= '0;
      ex_valid <= 1'b0; ex_pc <= '0; ex_rs <= '0; ex_rt <= '0; ex_dst <= '0;
      ex_imm <= '0; ex_aluop <= '0; ex_regwrite <= 1'b0; ex_memread <= 1'b0;
      ex_memwrite <= 1'b0; ex_branch <= 1'b0; ex_bne <= 1'b0; ex_jump <= 1'b0;
      ex_jr <= 1'b0; ex_link <= 1'b0; ex_illegal <= 1'b0;
    end else begin
      flag_a <= wb_enc && (wb_addrc == rf_addra) && (rf_addra != '0);
      flag_b <= wb_enc && (wb_addrc == rf_addrb) && (rf_addrb != '0);
      data_a <= wb_datac;
      data_b <= wb_datac;
      if (flush) ex_valid <= 1'b0;
      else if (upd && load_use) ex_valid <= 1'b0;
      else if (upd && if_valid) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_rs       <= i_rs;
        ex_rt       <= i_rt;
        ex_dst      <= d_dst;
        ex_imm      <= d_zext ? {{(XLEN-16){1'b0}}, i_imm} : {{(XLEN-16){i_imm[15]}}, i_imm};
        ex_aluop    <= d_aluop;
        ex_regwrite <= d_rw && (d_dst != '0);
        ex_memread  <= d_mr;
        ex_memwrite <= d_mw;
        ex_branch   <= d_br;
        ex_bne      <= d_bne;
        ex_jump     <= d_j;
        ex_jr       <= d_jr;
        ex_link     <= d_link;
        ex_illegal  <= d_ill;
      end else if (upd) ex_valid <= 1'b0;
    end
  end

  assign ex_rsdata = (ex_rs == '0) ? '0 : flag_a ? data_a : rf_dataa;
  assign ex_rtdata = (ex_rt == '0) ? '0 : flag_b ? data_b : rf_datab;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
MIPS instruction-decode stage that sits directly upstream of the register file. It accepts fetched instructions and drives the register-file read addresses, so operand data from the file's clocked reads lines up with its registered ID/EX outputs. It decodes control fields, bypasses same-cycle write-back hazards, detects load-use hazards and applies valid/ready backpressure toward fetch and execute.

Parameters:
XLEN, 32, data/instruction/PC width
RA, 5, register address width

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
if_valid  in  1  fetch presents instruction
if_ready  out  1  decode accepts this cycle
if_instr  in  XLEN  instruction word
if_pc  in  XLEN  PC of if_instr
flush  in  1  branch/jump redirect; kill decode contents
rf_addra  out  RA  register file read address A (combinational)
rf_addrb  out  RA  register file read address B (combinational)
rf_dataa  in  XLEN  register file data A, valid the cycle after address
rf_datab  in  XLEN  register file data B
wb_enc  in  1  write-back enable (same signal feeding the file's enc)
wb_addrc  in  RA  write-back address
wb_datac  in  XLEN  write-back data
ex_valid  out  1  ID/EX holds a valid instruction
ex_ready  in  1  execute accepts ID/EX contents
ex_pc  out  XLEN  PC
ex_rs, ex_rt, ex_dst  out  RA  source and destination registers
ex_rsdata, ex_rtdata  out  XLEN  operands after bypass
ex_imm  out  XLEN  extended immediate (sign; zero for andi/ori/xori)
ex_aluop  out  4  0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 sll,8 srl,9 lui,10 addu/subu-unsigned path
ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_bne, ex_jump, ex_jr, ex_link, ex_illegal  out  1  control flags

Behaviour:
- Reset: all ex_* outputs 0; bypass flags 0. if_ready=1 in the cycle after reset.
- load: upd = !ex_valid || ex_ready.
- load_use = ex_valid && ex_memread && ex_dst!=0 && (ex_dst==if_instr[25:21] || (ex_dst==if_instr[20:16] && the instruction reads rt)).
- if_ready = upd && !load_use && !flush.
- Address mux: if upd, rf_addra/rf_addrb = if_instr[25:21]/[20:16]; otherwise ex_rs/ex_rt. A held instruction re-reads its operands every cycle and stays current.
- Edge update, in priority order:
  - reset.
  - flush: ex_valid<=0.
  - upd && load_use: ex_valid<=0 (bubble); instruction stays at fetch.
  - upd && if_valid: latch decoded fields, ex_valid<=1.
  - upd && !if_valid: ex_valid<=0.
  - else: hold.
- Bypass: at each edge, flag_a<=wb_enc && wb_addrc==rf_addra && rf_addra!=0, and data_a<=wb_datac. Same for B.
- Operand select: ex_rsdata = (ex_rs==0) ? 0 : flag_a ? data_a : rf_dataa. ex_rtdata likewise.
- Decode, R-type (op 0), by funct:
  - 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 00 sll, 02 srl: regwrite, dst=rd.
  - 08 jr: jr=1, regwrite=0.
- Decode, I-type, dst=rt: 08 addi, 09 addiu, 0A slti, 0C andi, 0D ori, 0E xori, 0F lui.
- Memory: 23 lw (memread, regwrite, aluop add); 2B sw (memwrite, reads rt).
- Branches: 04 beq, 05 bne (branch; bne flag; sub; read rt).
- Jumps: 02 j (jump); 03 jal (jump, link, regwrite, dst=31).
- Other opcode/funct: ex_illegal=1, all side-effect flags 0.
- regwrite is forced 0 when dst==0.
- Simultaneous flush and load_use: flush wins; no stall is asserted.

Test Plan:
- Reset, then addiu $1,$0,5 with if_valid=1 -> next cycle ex_valid=1, ex_dst=1, ex_imm=5, ex_regwrite=1, ex_rsdata=0.
- Load-use: lw $2,0($1) then add $3,$2,$2 -> if_ready=0 for one cycle, ex_valid=0 bubble, then add issues with ex_rs=ex_rt=2.
- Bypass: wb_enc=1, wb_addrc=4, wb_datac=0xDEADBEEF in the cycle or $5,$4,$0 enters -> ex_rsdata=0xDEADBEEF even though rf_dataa is stale.
- Backpressure: ex_ready=0 for 3 cycles with a write to ex_rs during the stall -> ex_* held, rf_addra=ex_rs, ex_rsdata tracks the new value, if_ready=0.
- Flush while load_use is pending -> ex_valid=0, if_ready=0 that cycle; fetch presents the redirected instruction afterwards.
- Illegal opcode 0x3F -> ex_illegal=1, regwrite/memwrite/branch=0. addi $0,$0,1 -> regwrite=0. andi with imm 0x8000 -> ex_imm=0x00008000.
